// File: rtl/heap_sort_pkg.sv
// Shared types and helpers for the heap-sort engine: FSM state encoding,
// default sizing and the key-count clamp.
package heap_sort_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEPTH      = 1 << DEF_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BUILD,
    SIFT,
    WRITE,
    EXTRACT,
    FINISH
  } state_t;

  // Requests longer than the local array are sorted as a full array.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/heap_sort_engine_if.sv
// Sequencer-facing bundle of the heap-sort engine: start/busy/done handshake,
// source ROM read port and destination RAM write port.
interface heap_sort_engine_if
  import heap_sort_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              start;
  logic [ADDR_W:0]   len;
  logic              mode;
  logic              busy;
  logic              done;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_a;
  logic [DATA_W-1:0] rom_q;
  logic              ram_valid;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_d;

  modport master (
    output start, len, mode, rom_q,
    input  busy, done, rom_rd, rom_a, ram_valid, ram_a, ram_d
  );

  modport slave (
    input  start, len, mode, rom_q,
    output busy, done, rom_rd, rom_a, ram_valid, ram_a, ram_d
  );

endinterface

// File: rtl/heap_sift_sel.sv
// One sift-down decision: picks the winning child of node k and says whether
// it must swap with k. Holds the only copy of the ordering and tie rules.
module heap_sift_sel
  import heap_sort_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W:0]   k,
  input  logic [ADDR_W:0]   num,
  input  logic              mode,
  input  logic [DATA_W-1:0] a_k,
  input  logic [DATA_W-1:0] a_l,
  input  logic [DATA_W-1:0] a_r,
  output logic [ADDR_W:0]   sel,
  output logic              swap_en
);

  logic [ADDR_W+1:0] l;
  logic [ADDR_W+1:0] r;
  logic              l_ok;
  logic              r_ok;
  logic              take_r;
  logic [DATA_W-1:0] a_c;

  // Strict comparison: equal keys never win, so ties keep the left child / parent.
  function automatic logic beats(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                 input logic m);
    return m ? (a < b) : (a > b);
  endfunction

  always_comb begin
    l       = {k, 1'b0};
    r       = {k, 1'b1};
    l_ok    = (l <= {1'b0, num});
    r_ok    = (r <= {1'b0, num});
    take_r  = r_ok && beats(a_r, a_l, mode);
    a_c     = take_r ? a_r : a_l;
    sel     = take_r ? r[ADDR_W:0] : l[ADDR_W:0];
    swap_en = l_ok && beats(a_c, a_k, mode);
  end

endmodule

// File: rtl/heap_sort_engine.sv
// In-place heap sort: loads len keys from ROM, heapifies, then repeatedly
// extracts the root into RAM from the highest address downwards.
module heap_sort_engine
  import heap_sort_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  heap_sort_engine_if.slave  bus
);

  localparam int CAP = 1 << ADDR_W;

  typedef logic [ADDR_W:0] idx_t;

  state_t state;
  state_t state_nx;
  state_t ret;

  idx_t len_c;
  idx_t len_q;
  idx_t num;
  idx_t cnt;
  idx_t i;
  idx_t k;
  logic mode_q;

  logic [DATA_W-1:0] heap [1:CAP];
  logic [DATA_W-1:0] a_k;
  logic [DATA_W-1:0] a_l;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] a_sel;
  idx_t              sel;
  logic              swap_en;

  assign len_c = idx_t'(clamp_len(32'(bus.len), CAP));

  // Child indices may run past the array; those reads are masked to zero.
  function automatic logic [DATA_W-1:0] rd_heap(input idx_t ix);
    return (ix >= idx_t'(1) && ix <= idx_t'(CAP)) ? heap[ix] : '0;
  endfunction

  always_comb begin
    a_k   = rd_heap(k);
    a_l   = rd_heap({k[ADDR_W-1:0], 1'b0});
    a_r   = rd_heap({k[ADDR_W-1:0], 1'b1});
    a_sel = rd_heap(sel);
  end

  heap_sift_sel #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sel (
    .k       (k),
    .num     (num),
    .mode    (mode_q),
    .a_k     (a_k),
    .a_l     (a_l),
    .a_r     (a_r),
    .sel     (sel),
    .swap_en (swap_en)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (len_c == '0) ? FINISH : LOAD;
      LOAD:    if (cnt == len_q) state_nx = (len_q[ADDR_W:1] == '0) ? WRITE : BUILD;
      BUILD:   state_nx = SIFT;
      SIFT:    if (!swap_en) state_nx = ret;
      WRITE:   state_nx = (num == idx_t'(1)) ? FINISH : EXTRACT;
      EXTRACT: state_nx = SIFT;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.rom_rd    = 1'b0;
    bus.rom_a     = '0;
    bus.ram_valid = 1'b0;
    bus.ram_a     = '0;
    bus.ram_d     = '0;
    if (state != IDLE && state != FINISH) bus.busy = 1'b1;
    if (state == FINISH) bus.done = 1'b1;
    // The extra LOAD cycle only collects the last key, so no strobe there.
    if (state == LOAD && cnt != len_q) begin
      bus.rom_rd = 1'b1;
      bus.rom_a  = ADDR_W'(cnt);
    end
    if (state == WRITE) begin
      bus.ram_valid = 1'b1;
      bus.ram_a     = ADDR_W'(num - idx_t'(1));
      bus.ram_d     = heap[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q  <= '0;
      mode_q <= 1'b0;
      num    <= '0;
      cnt    <= '0;
      i      <= '0;
      k      <= '0;
      ret    <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && len_c != '0) begin
            len_q  <= len_c;
            mode_q <= bus.mode;
            num    <= len_c;
            cnt    <= '0;
          end
        end
        LOAD: begin
          cnt <= cnt + idx_t'(1);
          if (cnt == len_q) i <= len_q >> 1;
        end
        BUILD: begin
          k   <= i;
          i   <= i - idx_t'(1);
          ret <= (i == idx_t'(1)) ? WRITE : BUILD;
        end
        SIFT: begin
          if (swap_en) k <= sel;
        end
        EXTRACT: begin
          num <= num - idx_t'(1);
          k   <= idx_t'(1);
          ret <= WRITE;
        end
        default: ;
      endcase
    end
  end

  // Key storage carries no reset; every live slot is rewritten during LOAD.
  always_ff @(posedge clk) begin
    case (state)
      LOAD: begin
        if (cnt != '0) heap[cnt] <= bus.rom_q;
      end
      SIFT: begin
        if (swap_en) begin
          heap[k]   <= a_sel;
          heap[sel] <= a_k;
        end
      end
      EXTRACT: heap[1] <= heap[num];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_heap_sort_engine.sv
// Self-checking bench for heap_sort_engine: directed and random sorts checked
// against a sorted-array reference, plus handshake and mid-run reset cases.
module tb_heap_sort_engine;
  import heap_sort_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;

  heap_sort_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  heap_sort_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] vec_a [DEPTH] = '{3, 250, 7, 7, 0, 128, 1, 99, 64, 5, 200, 17, 17, 2, 255, 9};
  logic [7:0] rom_mem [DEPTH];
  logic [7:0] ram_mem [DEPTH] = '{default: 8'h00};
  logic [7:0] exp_mem [DEPTH];
  int wr_hits [DEPTH] = '{default: 0};
  int base_hits [DEPTH];
  int wr_log [$];
  int rd_log [$];
  int rd_count = 0;
  int wr_count = 0;
  int done_count = 0;
  int base_rd, base_wr, base_done, base_wlog, base_rlog;
  int total = 0;
  int bad = 0;

  // ROM with one-cycle read latency and a RAM that records every write.
  always @(posedge clk) begin
    if (bus.rom_rd) begin
      bus.rom_q <= rom_mem[bus.rom_a];
      rd_count  <= rd_count + 1;
      rd_log.push_back(int'(bus.rom_a));
    end
    if (bus.ram_valid) begin
      ram_mem[bus.ram_a] <= bus.ram_d;
      wr_hits[bus.ram_a] <= wr_hits[bus.ram_a] + 1;
      wr_count           <= wr_count + 1;
      wr_log.push_back(int'(bus.ram_a));
    end
    if (bus.done) done_count <= done_count + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_busy"}, 32'(bus.busy), 0);
    check_output({tag, "_done"}, 32'(bus.done), 0);
    check_output({tag, "_rom_rd"}, 32'(bus.rom_rd), 0);
    check_output({tag, "_rom_a"}, 32'(bus.rom_a), 0);
    check_output({tag, "_ram_valid"}, 32'(bus.ram_valid), 0);
    check_output({tag, "_ram_a"}, 32'(bus.ram_a), 0);
    check_output({tag, "_ram_d"}, 32'(bus.ram_d), 0);
  endtask

  // Reference: sort the first lc keys; ascending by address, or reversed.
  task automatic ref_sort(input int lc, input bit m);
    logic [7:0] v [DEPTH];
    logic [7:0] tmp;
    for (int a = 0; a < DEPTH; a++) v[a] = rom_mem[a];
    for (int a = 1; a < lc; a++)
      for (int b = a; b > 0 && v[b-1] > v[b]; b--) begin
        tmp = v[b]; v[b] = v[b-1]; v[b-1] = tmp;
      end
    for (int a = 0; a < DEPTH; a++)
      exp_mem[a] = (a >= lc) ? 8'h00 : (m ? v[lc-1-a] : v[a]);
  endtask

  task automatic snapshot();
    base_rd   = rd_count;
    base_wr   = wr_count;
    base_done = done_count;
    base_wlog = wr_log.size();
    base_rlog = rd_log.size();
    for (int a = 0; a < DEPTH; a++) base_hits[a] = wr_hits[a];
  endtask

  task automatic apply_stimulus(input int n, input bit m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 5'(n);
    bus.mode  = m;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int lc, input int pre);
    int limit, cyc, busy_low;
    limit = 1 + (lc + 1) + lc * (ADDR_W + 2) + lc * 2 * (ADDR_W + 1) + 1;
    cyc = 0;
    busy_low = 0;
    while (bus.done !== 1'b1 && cyc < limit + 4) begin
      if (bus.busy !== 1'b1) busy_low++;
      @(negedge clk);
      cyc++;
    end
    check_output({tag, "_done_seen"}, 32'(bus.done), 1);
    check_output({tag, "_busy_at_done"}, 32'(bus.busy), 0);
    check_output({tag, "_latency_in_bound"}, 32'(cyc + 2 + pre <= limit), 1);
    check_output({tag, "_busy_held"}, busy_low, 0);
  endtask

  task automatic verify_run(input string tag, input int lc);
    check_output({tag, "_done_pulses"}, done_count - base_done, 1);
    check_output({tag, "_rom_reads"}, rd_count - base_rd, lc);
    check_output({tag, "_ram_writes"}, wr_count - base_wr, lc);
    for (int a = 0; a < DEPTH; a++) begin
      check_output($sformatf("%s_hits%0d", tag, a), wr_hits[a] - base_hits[a], (a < lc) ? 1 : 0);
      if (a < lc) check_output($sformatf("%s_ram%0d", tag, a), 32'(ram_mem[a]), 32'(exp_mem[a]));
    end
    for (int j = 0; j < lc && base_wlog + j < wr_log.size(); j++)
      check_output($sformatf("%s_wr_order%0d", tag, j), wr_log[base_wlog + j], lc - 1 - j);
    for (int j = 0; j < lc && base_rlog + j < rd_log.size(); j++)
      check_output($sformatf("%s_rd_order%0d", tag, j), rd_log[base_rlog + j], j);
  endtask

  task automatic run_and_verify(input string tag, input int n, input bit m);
    int lc;
    lc = (n > DEPTH) ? DEPTH : n;
    snapshot();
    ref_sort(lc, m);
    apply_stimulus(n, m);
    finish_run(tag, lc, 0);
    @(negedge clk);
    check_output({tag, "_done_width"}, 32'(bus.done), 0);
    repeat (2) @(negedge clk);
    verify_run(tag, lc);
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.len   = '0;
    bus.mode  = 1'b0;
    #1;
    check_idle_outputs("in_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    for (int a = 0; a < DEPTH; a++) rom_mem[a] = vec_a[a];
    run_and_verify("asc16", 16, 1'b0);
    run_and_verify("desc16", 16, 1'b1);
    run_and_verify("clamp20", 20, 1'b0);

    rom_mem[0] = 8'd42;
    run_and_verify("len1", 1, 1'b0);
    run_and_verify("len0", 0, 1'b0);

    rom_mem[0] = 8'd9; rom_mem[1] = 8'd9; rom_mem[2] = 8'd9; rom_mem[3] = 8'd1; rom_mem[4] = 8'd1;
    run_and_verify("len5_ties", 5, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < DEPTH; a++) rom_mem[a] = 8'($urandom_range(0, (t % 2 == 1) ? 7 : 255));
      run_and_verify($sformatf("rand%0d", t), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    end

    // Handshake: stray start mid-sort, start coincident with done, then one cycle later.
    for (int a = 0; a < DEPTH; a++) rom_mem[a] = 8'($urandom_range(0, 255));
    snapshot();
    ref_sort(8, 1'b0);
    apply_stimulus(8, 1'b0);
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.len = 5'd3; bus.mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_run("hs1", 8, 11);
    bus.start = 1'b1; bus.len = 5'd5; bus.mode = 1'b1;
    @(negedge clk);
    check_output("hs_coincident_busy", 32'(bus.busy), 0);
    check_output("hs_coincident_rom_rd", 32'(bus.rom_rd), 0);
    verify_run("hs1", 8);
    for (int a = 0; a < DEPTH; a++) rom_mem[a] = 8'($urandom_range(0, 255));
    snapshot();
    ref_sort(5, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    check_output("hs_restart_busy", 32'(bus.busy), 1);
    check_output("hs_restart_rom_rd", 32'(bus.rom_rd), 1);
    check_output("hs_restart_rom_a", 32'(bus.rom_a), 0);
    finish_run("hs2", 5, 0);
    repeat (3) @(negedge clk);
    verify_run("hs2", 5);

    // Reset during the heapify phase aborts without writes or done.
    for (int a = 0; a < DEPTH; a++) rom_mem[a] = 8'($urandom_range(0, 255));
    apply_stimulus(16, 1'b0);
    repeat (25) @(negedge clk);
    check_output("rst_busy_before", 32'(bus.busy), 1);
    snapshot();
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check_output("rst_no_writes", wr_count - base_wr, 0);
    check_output("rst_no_done", done_count - base_done, 0);
    check_output("rst_idle_busy", 32'(bus.busy), 0);

    rom_mem[0] = 8'd4; rom_mem[1] = 8'd3; rom_mem[2] = 8'd2; rom_mem[3] = 8'd1;
    run_and_verify("post_rst", 4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
